// File: rtl/pipeline_stage_buf.sv
// Inter-stage pipeline register: payload plus single-shot pulse bits behind a
// valid/ready handshake, built either as a 2-entry skid buffer or a single register.
module pipeline_stage_buf #(
   parameter int PAYLOAD_W = 64,
   parameter int PULSE_W   = 1,
   parameter int SKID_EN   = 1
) (
   input  logic                 clk_i,
   input  logic                 arst_i,
   input  logic                 flush_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [PAYLOAD_W-1:0] payload_i,
   input  logic [PULSE_W-1:0]   pulse_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [PAYLOAD_W-1:0] payload_o,
   output logic [PULSE_W-1:0]   pulse_o,
   output logic [1:0]           occupancy_o
);

   // Handshake: an entry moves when valid and ready are both high at a rising
   // edge; in_fire additionally requires flush_i low, and the head is held
   // stable while valid_o & ~ready_i.
   generate
      if (SKID_EN != 0) begin : g_skid
         localparam logic [1:0] ST_EMPTY = 2'd0;
         localparam logic [1:0] ST_ONE   = 2'd1;
         localparam logic [1:0] ST_FULL  = 2'd2;

         logic [1:0]           state_q, state_d;
         logic [PAYLOAD_W-1:0] main_payload_q, main_payload_d;
         logic [PAYLOAD_W-1:0] skid_payload_q, skid_payload_d;
         logic [PULSE_W-1:0]   main_pulse_q, main_pulse_d;
         logic [PULSE_W-1:0]   skid_pulse_q, skid_pulse_d;
         logic                 main_valid, skid_valid, in_fire, out_fire;

         // ready_o depends only on the state register, so no path from ready_i.
         assign main_valid = (state_q != ST_EMPTY);
         assign skid_valid = (state_q == ST_FULL);
         assign in_fire    = valid_i & ~skid_valid & ~flush_i;
         assign out_fire   = main_valid & ready_i;

         always_comb begin
            state_d        = state_q;
            main_payload_d = main_payload_q;
            main_pulse_d   = main_pulse_q;
            skid_payload_d = skid_payload_q;
            skid_pulse_d   = skid_pulse_q;
            case (state_q)
               ST_EMPTY: begin
                  if (in_fire) begin
                     main_payload_d = payload_i;
                     main_pulse_d   = pulse_i;
                     state_d        = ST_ONE;
                  end
               end
               ST_ONE: begin
                  if (in_fire && out_fire) begin
                     main_payload_d = payload_i;
                     main_pulse_d   = pulse_i;
                  end else if (in_fire) begin
                     skid_payload_d = payload_i;
                     skid_pulse_d   = pulse_i;
                     state_d        = ST_FULL;
                  end else if (out_fire) begin
                     state_d = ST_EMPTY;
                  end
               end
               ST_FULL: begin
                  if (out_fire) begin
                     main_payload_d = skid_payload_q;
                     main_pulse_d   = skid_pulse_q;
                     state_d        = ST_ONE;
                  end
               end
               default: state_d = ST_EMPTY;
            endcase
            // Flush drops the valids only; stale payload is harmless once invalid.
            if (flush_i) begin
               state_d = ST_EMPTY;
            end
         end

         always_ff @(posedge clk_i) begin
            if (arst_i) begin
               state_q        <= ST_EMPTY;
               main_payload_q <= '0;
               main_pulse_q   <= '0;
               skid_payload_q <= '0;
               skid_pulse_q   <= '0;
            end else begin
               state_q        <= state_d;
               main_payload_q <= main_payload_d;
               main_pulse_q   <= main_pulse_d;
               skid_payload_q <= skid_payload_d;
               skid_pulse_q   <= skid_pulse_d;
            end
         end

         assign ready_o     = ~skid_valid;
         assign valid_o     = main_valid;
         assign payload_o   = main_payload_q;
         assign pulse_o     = main_pulse_q & {PULSE_W{out_fire}};
         assign occupancy_o = state_q;
      end else begin : g_single
         logic                 valid_q, valid_d;
         logic [PAYLOAD_W-1:0] payload_q, payload_d;
         logic [PULSE_W-1:0]   pulse_q, pulse_d;
         logic                 in_fire, out_fire;

         assign ready_o  = ~valid_q | ready_i;
         assign in_fire  = valid_i & ready_o & ~flush_i;
         assign out_fire = valid_q & ready_i;

         always_comb begin
            valid_d   = valid_q;
            payload_d = payload_q;
            pulse_d   = pulse_q;
            if (in_fire) begin
               valid_d   = 1'b1;
               payload_d = payload_i;
               pulse_d   = pulse_i;
            end else if (out_fire) begin
               valid_d = 1'b0;
            end
            if (flush_i) begin
               valid_d = 1'b0;
            end
         end

         always_ff @(posedge clk_i) begin
            if (arst_i) begin
               valid_q   <= 1'b0;
               payload_q <= '0;
               pulse_q   <= '0;
            end else begin
               valid_q   <= valid_d;
               payload_q <= payload_d;
               pulse_q   <= pulse_d;
            end
         end

         assign valid_o     = valid_q;
         assign payload_o   = payload_q;
         assign pulse_o     = pulse_q & {PULSE_W{out_fire}};
         assign occupancy_o = {1'b0, valid_q};
      end
   endgenerate

endmodule
